// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// sign-extend flag position and FSM state encoding.
package dmem_pkg;
  localparam logic [2:0] SIZE_B   = 3'b001;
  localparam logic [2:0] SIZE_H   = 3'b010;
  localparam logic [2:0] SIZE_W   = 3'b100;
  localparam int         SIGN_BIT = 3;

  typedef enum logic [1:0] {
    DMEM_IDLE  = 2'd0,
    DMEM_READ  = 2'd1,
    DMEM_WRITE = 2'd2
  } dmem_state_e;

  function automatic logic size_onehot(input logic [2:0] s);
    return (s == SIZE_B) || (s == SIZE_H) || (s == SIZE_W);
  endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus: the MEM stage is the master, the responder the slave.
interface data_mem_responder_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;
  logic        access_err;

  modport master (
    output addr, write_data, memwrite, memread, sign_mask,
    input  read_data, clk_stall, access_err
  );
  modport slave (
    input  addr, write_data, memwrite, memread, sign_mask,
    output read_data, clk_stall, access_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte/half/word lane handling: extracts and extends a load from a RAM word,
// and merges right-aligned store data into that word for write-back.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [3:0]  sign_mask_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  always_comb begin
    b       = word_i[{lane_i, 3'b000} +: 8];
    h       = lane_i[1] ? word_i[31:16] : word_i[15:0];
    sx      = sign_mask_i[SIGN_BIT];
    load_o  = '0;
    store_o = word_i;
    case (sign_mask_i[2:0])
      SIZE_B: begin
        load_o = {{24{sx & b[7]}}, b};
        store_o[{lane_i, 3'b000} +: 8] = write_data_i[7:0];
      end
      SIZE_H: begin
        load_o = {{16{sx & h[15]}}, h};
        if (lane_i[1]) store_o[31:16] = write_data_i[15:0];
        else           store_o[15:0]  = write_data_i[15:0];
      end
      SIZE_W: begin
        load_o  = word_i;
        store_o = write_data_i;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: legality check, IDLE/READ/WRITE FSM and a single-port
// word RAM; sub-word stores are read-modify-write through dmem_lane_align.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_responder_if.slave bus
);
  localparam int          WIDX = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);

  dmem_state_e     state_q;
  logic [WIDX+1:0] off_q;
  logic [31:0]     wdata_q;
  logic [3:0]      mask_q;
  logic            store_q;
  logic [31:0]     rdata_q;
  logic [31:0]     read_data_q;
  logic            err_q;

  logic [32:0]     off_full;
  logic            in_range, aligned, legal, req_any, req_ok;
  logic [31:0]     load_val, store_word;

  // 33-bit subtraction: addresses below BASE_ADDR land above SPAN and fail the check.
  always_comb begin
    off_full = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
    in_range = !off_full[32] && (off_full < SPAN);
    case (bus.sign_mask[2:0])
      SIZE_B:  aligned = 1'b1;
      SIZE_H:  aligned = !bus.addr[0];
      SIZE_W:  aligned = (bus.addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    legal   = size_onehot(bus.sign_mask[2:0]) && aligned && in_range;
    req_any = bus.memread | bus.memwrite;
    req_ok  = (bus.memread ^ bus.memwrite) & legal;
  end

  // RAM read is issued on the accept edge so the word is ready during READ.
  logic [31:0]     mem [DEPTH_WORDS];
  logic            ram_we, ram_re;
  logic [WIDX-1:0] ram_idx;

  assign ram_we  = (state_q == DMEM_WRITE);
  assign ram_re  = (state_q == DMEM_IDLE) && req_ok;
  assign ram_idx = ram_we ? off_q[WIDX+1:2] : off_full[WIDX+1:2];

  always_ff @(posedge clk) begin
    if (ram_we)      mem[ram_idx] <= store_word;
    else if (ram_re) rdata_q      <= mem[ram_idx];
  end

  dmem_lane_align u_align (
    .word_i       (rdata_q),
    .lane_i       (off_q[1:0]),
    .sign_mask_i  (mask_q),
    .write_data_i (wdata_q),
    .load_o       (load_val),
    .store_o      (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DMEM_IDLE;
      off_q       <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      store_q     <= 1'b0;
      read_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        DMEM_IDLE: begin
          if (req_ok) begin
            off_q   <= off_full[WIDX+1:0];
            wdata_q <= bus.write_data;
            mask_q  <= bus.sign_mask;
            store_q <= bus.memwrite;
            state_q <= DMEM_READ;
          end else if (req_any) begin
            err_q <= 1'b1;
          end
        end
        DMEM_READ: begin
          if (store_q) state_q <= DMEM_WRITE;
          else begin
            read_data_q <= load_val;
            state_q     <= DMEM_IDLE;
          end
        end
        DMEM_WRITE: state_q <= DMEM_IDLE;
        default:    state_q <= DMEM_IDLE;
      endcase
    end
  end

  assign bus.read_data  = read_data_q;
  assign bus.access_err = err_q;
  assign bus.clk_stall  = (state_q != DMEM_IDLE) | req_ok;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: stores, loads, sub-word merges,
// illegal requests and reset during a store.
module tb_data_mem_responder;
  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cnt;
  logic err;

  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for its accept cycle, then counts stall cycles until idle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        output int c, output logic e);
    @(negedge clk);
    bus.memread = rd; bus.memwrite = wr; bus.addr = a;
    bus.write_data = d; bus.sign_mask = m;
    #1;
    c = bus.clk_stall ? 1 : 0;
    @(posedge clk); #1;
    e = bus.access_err;
    bus.memread = 1'b0; bus.memwrite = 1'b0;
    if (c > 0)
      while (bus.clk_stall && c < 10) begin
        c++;
        @(posedge clk); #1;
      end
  endtask

  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    access(1'b0, 1'b1, a, d, m, cnt, err);
    chk({tag, "_stall"}, 32'(cnt), 32'd3);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] exp);
    access(1'b1, 1'b0, a, 32'h0, m, cnt, err);
    chk({tag, "_stall"}, 32'(cnt), 32'd2);
    chk({tag, "_data"}, bus.read_data, exp);
  endtask

  task automatic illegal(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [3:0] m);
    access(rd, wr, a, 32'hFFFF_FFFF, m, cnt, err);
    chk({tag, "_stall"}, 32'(cnt), 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_errpulse"}, {31'd0, bus.access_err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.addr = '0; bus.write_data = '0; bus.memread = 1'b0;
    bus.memwrite = 1'b0; bus.sign_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_read_data", bus.read_data, 32'h0);
    chk("rst_stall", {31'd0, bus.clk_stall}, 32'd0);
    chk("rst_err", {31'd0, bus.access_err}, 32'd0);

    store("sw_10", 32'h10, 32'hDEAD_BEEF, 4'b0100);
    load("lw_10", 32'h10, 4'b0100, 32'hDEAD_BEEF);

    store("sw_10_zero", 32'h10, 32'h0, 4'b0100);
    store("sb_11", 32'h11, 32'h0000_0080, 4'b0001);
    load("lb_11", 32'h11, 4'b1001, 32'hFFFF_FF80);
    load("lbu_11", 32'h11, 4'b0001, 32'h0000_0080);
    load("lw_after_sb", 32'h10, 4'b0100, 32'h0000_8000);

    store("sh_12", 32'h12, 32'h0000_BEEF, 4'b0010);
    load("lh_12", 32'h12, 4'b1010, 32'hFFFF_BEEF);
    load("lhu_12", 32'h12, 4'b0010, 32'h0000_BEEF);
    illegal("lh_13", 1'b1, 1'b0, 32'h13, 4'b1010);
    chk("lh_13_hold", bus.read_data, 32'h0000_BEEF);
    load("lw_after_sh", 32'h10, 4'b1100, 32'hBEEF_8000);

    store("sw_first", 32'h0, 32'hA5A5_A5A5, 4'b0100);
    store("sw_last", 32'hFFC, 32'h5A5A_5A5A, 4'b0100);
    illegal("sw_oor", 1'b0, 1'b1, 32'h1000, 4'b0100);
    load("lw_first", 32'h0, 4'b0100, 32'hA5A5_A5A5);
    load("lw_last", 32'hFFC, 4'b0100, 32'h5A5A_5A5A);

    illegal("rd_wr_both", 1'b1, 1'b1, 32'h0, 4'b0100);
    load("lw_first_2", 32'h0, 4'b0100, 32'hA5A5_A5A5);
    illegal("bad_size", 1'b1, 1'b0, 32'h0, 4'b0011);
    illegal("sw_misalign", 1'b0, 1'b1, 32'h2, 4'b0100);
    load("lw_first_3", 32'h0, 4'b0100, 32'hA5A5_A5A5);

    store("sw_20", 32'h20, 32'h0BAD_F00D, 4'b0100);
    load("lw_20", 32'h20, 4'b0100, 32'h0BAD_F00D);
    // Store 0x1234 aborted by reset while in WRITE.
    @(negedge clk);
    bus.memwrite = 1'b1; bus.addr = 32'h20; bus.write_data = 32'h1234;
    bus.sign_mask = 4'b0100;
    @(posedge clk); #1;
    bus.memwrite = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_write_stall", {31'd0, bus.clk_stall}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("abort_stall", {31'd0, bus.clk_stall}, 32'd0);
    chk("abort_read_data", bus.read_data, 32'h0);
    chk("abort_err", {31'd0, bus.access_err}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    load("lw_20_after_abort", 32'h20, 4'b0100, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
